// File: rtl/secded_pkg.sv
// Shared types and constants for the SECDED decode engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package secded_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    CAP_HI,
    DECODE,
    WR_HI,
    WR_LO,
    DONE
  } state_t;

  // Status flag written into the top two bits of each result hi byte.
  localparam logic [1:0] F_NONE   = 2'b00;
  localparam logic [1:0] F_SINGLE = 2'b01;
  localparam logic [1:0] F_DOUBLE = 2'b10;

  // Parity bit positions inside the 16-bit codeword; all other positions carry data.
  localparam int P8_POS = 8;
  localparam int P4_POS = 4;
  localparam int P2_POS = 2;
  localparam int P1_POS = 1;
  localparam int P0_POS = 0;

endpackage

// File: rtl/secded_syndrome.sv
// Combinational SECDED check of one 16-bit codeword: corrected data and status flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module secded_syndrome
  import secded_pkg::*;
(
  input  logic [15:0] cw,
  output logic [11:1] data,
  output logic [1:0]  flag
);

  logic [3:0]  syn;
  logic        par;
  logic [15:0] fixed;

  // Syndrome is the XOR of the indices of all set bits; overall parity picks single vs double.
  always_comb begin
    syn = '0;
    for (int k = 1; k < 16; k++) begin
      if (cw[k]) syn = syn ^ 4'(k);
    end
    par   = ^cw;
    fixed = cw;
    flag  = F_NONE;
    if (par) begin
      // Odd overall parity: one flipped bit at position syn (syn=0 is p0 itself).
      fixed[syn] = ~cw[syn];
      flag       = F_SINGLE;
    end else if (syn != 4'd0) begin
      // Even parity with a nonzero syndrome: two flips, data left as received.
      flag = F_DOUBLE;
    end
    data = {fixed[15:P8_POS+1], fixed[P8_POS-1:P4_POS+1], fixed[P4_POS-1]};
  end

endmodule

// File: rtl/secded_decode_engine.sv
// Reads N_MSG codewords from memory, corrects/flags them, writes data+status back.
// Latency: 6 cycles per codeword; done rises 1 + 6*N_MSG cycles after req is sampled.
// Backpressure: none; req is ignored while busy, memory is assumed always ready.
module secded_decode_engine
  import secded_pkg::*;
#(
  parameter int N_MSG    = 15,
  parameter int IN_BASE  = 30,
  parameter int OUT_BASE = 0,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  output logic          done,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  output logic [3:0]    err1_cnt,
  output logic [3:0]    err2_cnt
);

  localparam int            IW   = (N_MSG > 1) ? $clog2(N_MSG) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_MSG - 1);

  state_t        state, state_nx;
  logic [IW-1:0] idx;
  logic [7:0]    lo_q, hi_q;
  logic [11:1]   dec_data, data_q;
  logic [1:0]    dec_flag, flag_q;
  logic [AW-1:0] addr_hold;
  logic [AW-1:0] off;
  logic          start;

  secded_syndrome u_syndrome (
    .cw   ({hi_q, lo_q}),
    .data (dec_data),
    .flag (dec_flag)
  );

  assign start = req && (state == IDLE || state == DONE);
  assign off   = AW'(idx) << 1;
  assign busy  = (state != IDLE) && (state != DONE);

  // Next-state sequencing: a fixed six-step walk per codeword.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (req) state_nx = RD_LO;
      RD_LO:      state_nx = RD_HI;
      RD_HI:      state_nx = CAP_HI;
      CAP_HI:     state_nx = DECODE;
      DECODE:     state_nx = WR_HI;
      WR_HI:      state_nx = WR_LO;
      WR_LO:      state_nx = (idx == LAST) ? DONE : RD_LO;
      default:    state_nx = IDLE;
    endcase
  end

  // Memory port drive; the address holds its previous value in non-accessing states.
  always_comb begin
    mem_addr    = addr_hold;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'h00;
    case (state)
      RD_LO: mem_addr = AW'(IN_BASE) + off;
      RD_HI: mem_addr = AW'(IN_BASE) + off + AW'(1);
      WR_HI: begin
        mem_addr    = AW'(OUT_BASE) + off + AW'(1);
        mem_wr_en   = 1'b1;
        mem_wr_data = {flag_q, 3'b000, data_q[11:9]};
      end
      WR_LO: begin
        mem_addr    = AW'(OUT_BASE) + off;
        mem_wr_en   = 1'b1;
        mem_wr_data = data_q[8:1];
      end
      default: ;
    endcase
  end

  // State, index, captured bytes, decoded result, counters and the lagging done flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      data_q    <= '0;
      flag_q    <= F_NONE;
      err1_cnt  <= '0;
      err2_cnt  <= '0;
      done      <= 1'b0;
      addr_hold <= '0;
    end else begin
      state     <= state_nx;
      addr_hold <= mem_addr;
      done      <= (state == DONE);
      if (start) begin
        idx      <= '0;
        err1_cnt <= '0;
        err2_cnt <= '0;
      end
      // Read data lags its address by one cycle, hence capture one state later.
      if (state == RD_HI)  lo_q <= mem_rd_data;
      if (state == CAP_HI) hi_q <= mem_rd_data;
      if (state == DECODE) begin
        data_q <= dec_data;
        flag_q <= dec_flag;
        if (dec_flag == F_SINGLE && err1_cnt != 4'hF) err1_cnt <= err1_cnt + 4'd1;
        if (dec_flag == F_DOUBLE && err2_cnt != 4'hF) err2_cnt <= err2_cnt + 4'd1;
      end
      if (state == WR_LO && idx != LAST) idx <= idx + IW'(1);
    end
  end

endmodule

// File: tb/tb_secded_decode_engine.sv
// Bench for secded_decode_engine: directed and random codeword batches against a reference model.
// Latency: checks done at exactly 1 + 6*N_MSG cycles after req is sampled.
// Backpressure: none; memory model answers every access.
module tb_secded_decode_engine;

  localparam int N    = 15;
  localparam int AW   = 8;
  localparam int INB  = 30;
  localparam int OUTB = 0;
  localparam int DONE_CYC = 1 + 6 * N;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req = 1'b0;
  logic          done, busy, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rd_data, mem_wr_data;
  logic [3:0]    err1_cnt, err2_cnt;

  logic [7:0]    mem [256];
  logic          ld_en = 1'b0;
  logic [7:0]    ld_addr = 8'h00;
  logic [7:0]    ld_data = 8'h00;
  int            stray_wr = 0;

  int            n_cmp = 0;
  int            n_bad = 0;

  logic [15:0]   cw_in [N];
  logic [7:0]    exp_hi [N];
  logic [7:0]    exp_lo [N];
  int            exp_e1, exp_e2;

  always #5 clk = ~clk;

  secded_decode_engine dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .busy        (busy),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .err1_cnt    (err1_cnt),
    .err2_cnt    (err2_cnt)
  );

  // Synchronous-read memory with a bench-side load port; writes outside the result area are counted.
  always @(posedge clk) begin
    mem_rd_data <= mem[mem_addr];
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      if (mem_addr >= 8'(OUTB + 2 * N)) stray_wr <= stray_wr + 1;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_pow2(input int k);
    return (k & (k - 1)) == 0;
  endfunction

  // Reference encoder: data in non-power-of-two slots, parity bits zero the syndrome, p0 makes parity even.
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    int j, s;
    c = '0; j = 0; s = 0;
    for (int k = 1; k < 16; k++) begin
      if (!is_pow2(k)) begin c[k] = d[j]; j++; end
    end
    for (int k = 1; k < 16; k++) if (c[k]) s = s ^ k;
    for (int b = 0; b < 4; b++) if (s[b]) c[1 << b] = 1'b1;
    c[0] = ^c;
    return c;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] c);
    logic [10:0] d;
    int j;
    d = '0; j = 0;
    for (int k = 1; k < 16; k++) begin
      if (!is_pow2(k)) begin d[j] = c[k]; j++; end
    end
    return d;
  endfunction

  task automatic load_byte(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
  endtask

  task automatic load_batch();
    for (int i = 0; i < N; i++) begin
      load_byte(8'(INB + 2 * i), cw_in[i][7:0]);
      load_byte(8'(INB + 2 * i + 1), cw_in[i][15:8]);
      load_byte(8'(OUTB + 2 * i), 8'hAA);
      load_byte(8'(OUTB + 2 * i + 1), 8'hAA);
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic setup_clean();
    for (int i = 0; i < N; i++) begin
      cw_in[i] = 16'hFFFF; exp_hi[i] = 8'h07; exp_lo[i] = 8'hFF;
    end
    exp_e1 = 0; exp_e2 = 0;
  endtask

  task automatic setup_directed();
    setup_clean();
    cw_in[0] = 16'h0020; exp_hi[0] = 8'h40; exp_lo[0] = 8'h00;
    cw_in[1] = 16'h0001; exp_hi[1] = 8'h40; exp_lo[1] = 8'h00;
    cw_in[2] = 16'h0028; exp_hi[2] = 8'h80; exp_lo[2] = 8'h03;
    exp_e1 = 2; exp_e2 = 1;
  endtask

  // One or two random flips of a valid codeword; the known flip count decides the expected outcome.
  task automatic setup_random();
    logic [10:0] d, r;
    logic [15:0] c;
    logic [1:0]  f;
    int a, b;
    exp_e1 = 0; exp_e2 = 0;
    for (int i = 0; i < N; i++) begin
      d = 11'($urandom);
      c = encode(d);
      a = $urandom_range(0, 15);
      c[a] = ~c[a];
      if ($urandom_range(0, 1) == 1) begin
        do b = $urandom_range(0, 15); while (b == a);
        c[b] = ~c[b];
        r = extract(c); f = 2'b10; exp_e2++;
      end else begin
        r = d; f = 2'b01; exp_e1++;
      end
      cw_in[i]  = c;
      exp_hi[i] = {f, 3'b000, r[10:8]};
      exp_lo[i] = r[7:0];
    end
  endtask

  task automatic run_batch(input string name, input int pulse_at, input int reset_at);
    int cyc;
    load_batch();
    @(negedge clk) req = 1'b1;
    @(negedge clk) req = 1'b0;
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk({name, "_busy_c1"}, 32'(busy), 32'd1);
        chk({name, "_done_c1"}, 32'(done), 32'd0);
      end
      if (cyc == reset_at) begin
        chk({name, "_busy_prerst"}, 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk({name, "_rst_done"}, 32'(done), 32'd0);
        chk({name, "_rst_busy"}, 32'(busy), 32'd0);
        chk({name, "_rst_wr_en"}, 32'(mem_wr_en), 32'd0);
        chk({name, "_rst_e1"}, 32'(err1_cnt), 32'd0);
        chk({name, "_rst_addr"}, 32'(mem_addr), 32'd0);
        @(negedge clk) reset = 1'b0;
        return;
      end
      if (done) break;
      req = (cyc == pulse_at);
    end
    req = 1'b0;
    chk({name, "_done_cycle"}, 32'(cyc), 32'(DONE_CYC));
    chk({name, "_busy_end"}, 32'(busy), 32'd0);
    chk({name, "_err1"}, 32'(err1_cnt), 32'(exp_e1));
    chk({name, "_err2"}, 32'(err2_cnt), 32'(exp_e2));
    chk({name, "_errsum"}, 32'(err1_cnt) + 32'(err2_cnt), 32'(exp_e1 + exp_e2));
    chk({name, "_stray_wr"}, 32'(stray_wr), 32'd0);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_hi%0d", name, i), 32'(mem[OUTB + 2 * i + 1]), 32'(exp_hi[i]));
      chk($sformatf("%s_lo%0d", name, i), 32'(mem[OUTB + 2 * i]), 32'(exp_lo[i]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wr_data", 32'(mem_wr_data), 32'd0);
    chk("rst_err1", 32'(err1_cnt), 32'd0);
    chk("rst_err2", 32'(err2_cnt), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    setup_clean();     run_batch("clean", -1, -1);
    setup_directed();  run_batch("directed", 40, -1);
    setup_random();    run_batch("rand0", -1, -1);
    setup_random();    run_batch("rand_rst", -1, 50);
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);
    setup_random();    run_batch("rand1", -1, -1);
    setup_random();    run_batch("rand2", -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
